// File: rtl/shifter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shifter_pkg
// Description : Mode encodings and level-to-stage mapping for pipelined_shifter.
// Revision    : 1.0 - initial release
// ============================================================================
package shifter_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] SH_SLL = 3'b000;
    localparam logic [MODE_W-1:0] SH_SRL = 3'b001;
    localparam logic [MODE_W-1:0] SH_SRA = 3'b010;
    localparam logic [MODE_W-1:0] SH_ROL = 3'b011;
    localparam logic [MODE_W-1:0] SH_ROR = 3'b100;

    function automatic int stage_of_level(input int lvl, input int stages, input int levels);
        return (lvl * stages) / levels;
    endfunction

    // Lowest level index owned by a stage; returns levels for stg == stages.
    function automatic int first_level(input int stg, input int stages, input int levels);
        int r;
        r = levels;
        for (int i = levels - 1; i >= 0; i--) begin
            if (stage_of_level(i, stages, levels) >= stg) begin
                r = i;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_level.sv
`default_nettype none
// ============================================================================
// Module      : shift_level
// Description : One combinational shift level of fixed distance DIST.
//               Rotates are built only when SHIFTER_ROT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_level
    import shifter_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int DIST = 1
) (
    input  logic [XLEN-1:0]   i_data,
    input  logic [MODE_W-1:0] i_mode,
    input  logic              i_en,
    input  logic              i_sign,
    output logic [XLEN-1:0]   o_data
);

    always_comb begin
        o_data = i_data;
        if (i_en) begin
            case (i_mode)
                SH_SLL:  o_data = i_data << DIST;
                SH_SRL:  o_data = i_data >> DIST;
                SH_SRA:  o_data = {{DIST{i_sign}}, i_data[XLEN-1:DIST]};
`ifdef SHIFTER_ROT_EN
                SH_ROL:  o_data = {i_data[XLEN-1-DIST:0], i_data[XLEN-1:XLEN-DIST]};
                SH_ROR:  o_data = {i_data[DIST-1:0], i_data[XLEN-1:DIST]};
`endif
                default: o_data = i_data;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipelined_shifter.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_shifter
// Description : Valid/ready pipelined barrel shifter, log2(XLEN) levels split
//               over STAGES registers. Optional rotates via SHIFTER_ROT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_shifter
    import shifter_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [MODE_W-1:0]        in_mode,
    input  logic [XLEN-1:0]          in_data,
    input  logic [$clog2(XLEN)-1:0]  in_shamt,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_data,
    output logic [TAG_W-1:0]         out_tag
);

    localparam int LEVELS = $clog2(XLEN);

    logic                               w_advance;
    logic                               w_accept;

    logic [STAGES-1:0]                  r_valid;
    logic [STAGES-1:0][XLEN-1:0]        r_data;
    logic [STAGES-1:0][MODE_W-1:0]      r_mode;
    logic [STAGES-1:0][LEVELS-1:0]      r_shamt;
    logic [STAGES-1:0][TAG_W-1:0]       r_tag;

    logic [STAGES-1:0]                  w_sin_valid;
    logic [STAGES-1:0][XLEN-1:0]        w_sin_data;
    logic [STAGES-1:0][MODE_W-1:0]      w_sin_mode;
    logic [STAGES-1:0][LEVELS-1:0]      w_sin_shamt;
    logic [STAGES-1:0][TAG_W-1:0]       w_sin_tag;
    logic [STAGES-1:0][XLEN-1:0]        w_sout_data;

    logic [LEVELS-1:0][XLEN-1:0]        w_lvl_in;
    logic [LEVELS-1:0][XLEN-1:0]        w_lvl_out;

    // Global stall: the whole pipe moves only when the output slot can drain.
    assign w_advance = out_ready | ~r_valid[STAGES-1];
    assign w_accept  = in_valid & w_advance;
    assign in_ready  = w_advance;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int LAST = first_level(s + 1, STAGES, LEVELS) - 1;
        if (s == 0) begin : g_head
            assign w_sin_valid[s] = w_accept;
            assign w_sin_data[s]  = in_data;
            assign w_sin_mode[s]  = in_mode;
            assign w_sin_shamt[s] = in_shamt;
            assign w_sin_tag[s]   = in_tag;
        end else begin : g_link
            assign w_sin_valid[s] = r_valid[s-1];
            assign w_sin_data[s]  = r_data[s-1];
            assign w_sin_mode[s]  = r_mode[s-1];
            assign w_sin_shamt[s] = r_shamt[s-1];
            assign w_sin_tag[s]   = r_tag[s-1];
        end
        assign w_sout_data[s] = w_lvl_out[LAST];
    end

    for (genvar i = 0; i < LEVELS; i++) begin : g_level
        localparam int STG = stage_of_level(i, STAGES, LEVELS);
        if (i == first_level(STG, STAGES, LEVELS)) begin : g_first
            assign w_lvl_in[i] = w_sin_data[STG];
        end else begin : g_chain
            assign w_lvl_in[i] = w_lvl_out[i-1];
        end

        // SRA keeps the MSB intact, so the running MSB is the original sign.
        shift_level #(
            .XLEN (XLEN),
            .DIST (1 << i)
        ) u_level (
            .i_data (w_lvl_in[i]),
            .i_mode (w_sin_mode[STG]),
            .i_en   (w_sin_shamt[STG][i]),
            .i_sign (w_lvl_in[i][XLEN-1]),
            .o_data (w_lvl_out[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_data  <= '0;
            r_mode  <= '0;
            r_shamt <= '0;
            r_tag   <= '0;
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                if (flush) begin
                    r_valid[s] <= 1'b0;
                end else if (w_advance) begin
                    r_valid[s] <= w_sin_valid[s];
                end
                // Payload registers only load for live ops, idle stages stay quiet.
                if (w_advance && w_sin_valid[s] && !flush) begin
                    r_data[s]  <= w_sout_data[s];
                    r_mode[s]  <= w_sin_mode[s];
                    r_shamt[s] <= w_sin_shamt[s];
                    r_tag[s]   <= w_sin_tag[s];
                end
            end
        end
    end

    assign out_valid = r_valid[STAGES-1];
    assign out_data  = r_data[STAGES-1];
    assign out_tag   = r_tag[STAGES-1];

    // Last-stage mode/shamt and already-consumed shamt bits have no reader.
    logic w_unused;
    assign w_unused = ^{r_mode, r_shamt, w_sin_shamt};

endmodule
`default_nettype wire

// File: tb/tb_pipelined_shifter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_shifter
// Description : Directed vectors and corner sequences for pipelined_shifter
//               (32-bit/2-stage) plus a 64-bit/3-stage random sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_shifter;
    import shifter_pkg::*;

    localparam int S32 = 2;
    localparam int S64 = 3;
`ifdef SHIFTER_ROT_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_mode = '0;
    logic [31:0] in_data = '0;
    logic [4:0]  in_shamt = '0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [4:0]  out_tag;

    logic        b_in_valid = 1'b0;
    logic        b_in_ready;
    logic [2:0]  b_in_mode = '0;
    logic [63:0] b_in_data = '0;
    logic [5:0]  b_in_shamt = '0;
    logic [4:0]  b_in_tag = '0;
    logic        b_out_valid;
    logic [63:0] b_out_data;
    logic [4:0]  b_out_tag;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pipelined_shifter #(.XLEN(32), .STAGES(S32), .TAG_W(5)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_data(in_data), .in_shamt(in_shamt), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag)
    );

    pipelined_shifter #(.XLEN(64), .STAGES(S64), .TAG_W(5)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .flush(1'b0),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_mode(b_in_mode),
        .in_data(b_in_data), .in_shamt(b_in_shamt), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(1'b1),
        .out_data(b_out_data), .out_tag(b_out_tag)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_model(input logic [2:0] m, input logic [63:0] d,
                                              input int sh, input int xl);
        logic [63:0] mask, dx, r;
        mask = (xl == 64) ? '1 : ((64'd1 << xl) - 64'd1);
        dx   = d & mask;
        case (m)
            3'd0: r = (dx << sh) & mask;
            3'd1: r = dx >> sh;
            3'd2: begin
                if (dx[xl-1]) dx = dx | ~mask;
                r = 64'($signed(dx) >>> sh) & mask;
            end
            3'd3: r = (!ROT || sh == 0) ? dx : (((dx << sh) | (dx >> (xl - sh))) & mask);
            3'd4: r = (!ROT || sh == 0) ? dx : (((dx >> sh) | (dx << (xl - sh))) & mask);
            default: r = dx;
        endcase
        return r;
    endfunction

    // Issues one op on the 32-bit DUT, checks latency, data and tag.
    task automatic run32(input logic [2:0] m, input logic [31:0] d, input logic [4:0] sh,
                         input logic [4:0] tg, input logic [31:0] exp, input string nm);
        int n;
        out_ready = 1'b1;
        in_valid = 1'b1; in_mode = m; in_data = d; in_shamt = sh; in_tag = tg;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({nm, " latency"}, 64'(n), 64'(S32));
        check({nm, " data"}, 64'(out_data), 64'(exp));
        check({nm, " tag"}, 64'(out_tag), 64'(tg));
        @(posedge clk); #1;
    endtask

    task automatic run64(input logic [2:0] m, input logic [63:0] d, input logic [5:0] sh,
                         input logic [4:0] tg);
        int n;
        b_in_valid = 1'b1; b_in_mode = m; b_in_data = d; b_in_shamt = sh; b_in_tag = tg;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        n = 1;
        while (!b_out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("x64 latency", 64'(n), 64'(S64));
        check("x64 data", b_out_data, ref_model(m, d, int'(sh), 64));
        check("x64 tag", 64'(b_out_tag), 64'(tg));
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [2:0]  mode;
        logic [31:0] data;
        logic [4:0]  shamt;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[18];

    logic [2:0]  s_mode[4];
    logic [31:0] s_data[4];
    logic [4:0]  s_sh[4];
    logic [31:0] s_exp[4];

    initial begin
        vecs[0]  = '{3'd0, 32'h0000_0001, 5'd31, 32'h8000_0000};
        vecs[1]  = '{3'd2, 32'h8000_0000, 5'd4,  32'hF800_0000};
        vecs[2]  = '{3'd1, 32'h8000_0000, 5'd4,  32'h0800_0000};
        vecs[3]  = '{3'd0, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
        vecs[4]  = '{3'd1, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
        vecs[5]  = '{3'd2, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
        vecs[6]  = '{3'd3, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
        vecs[7]  = '{3'd4, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
        vecs[8]  = '{3'd7, 32'hDEAD_BEEF, 5'd5,  32'hDEAD_BEEF};
        vecs[9]  = '{3'd5, 32'h1234_5678, 5'd13, 32'h1234_5678};
        vecs[10] = '{3'd3, 32'h8000_0001, 5'd1,  ROT ? 32'h0000_0003 : 32'h8000_0001};
        vecs[11] = '{3'd4, 32'h0000_0001, 5'd1,  ROT ? 32'h8000_0000 : 32'h0000_0001};
        vecs[12] = '{3'd2, 32'h7FFF_0000, 5'd16, 32'h0000_7FFF};
        vecs[13] = '{3'd0, 32'hDEAD_BEEF, 5'd8,  32'hADBE_EF00};
        vecs[14] = '{3'd2, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF};
        vecs[15] = '{3'd1, 32'hFFFF_FFFF, 5'd31, 32'h0000_0001};
        vecs[16] = '{3'd3, 32'h1234_5678, 5'd4,  ROT ? 32'h2345_6781 : 32'h1234_5678};
        vecs[17] = '{3'd4, 32'h1234_5678, 5'd8,  ROT ? 32'h7812_3456 : 32'h1234_5678};

        s_mode = '{3'd0, 3'd1, 3'd2, 3'd0};
        s_data = '{32'h0000_00F0, 32'hF000_0000, 32'h8000_0000, 32'h0000_0003};
        s_sh   = '{5'd4, 5'd8, 5'd1, 5'd30};
        s_exp  = '{32'h0000_0F00, 32'h00F0_0000, 32'hC000_0000, 32'hC000_0000};

        // Reset state, both during and after reset.
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset out_data", 64'(out_data), 64'd0);
        check("reset out_tag", 64'(out_tag), 64'd0);
        check("reset in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post-reset out_valid", 64'(out_valid), 64'd0);
        check("post-reset in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 18; i++) begin
            run32(vecs[i].mode, vecs[i].data, vecs[i].shamt, 5'(i + 1), vecs[i].exp,
                  $sformatf("vec%0d", i));
        end

        // Back-to-back stream with a 3-cycle output stall in the middle.
        begin
            int sent, rcvd;
            logic hold_v;
            logic [31:0] hold_d;
            logic [4:0] hold_t;
            sent = 0; rcvd = 0; hold_v = 1'b0; hold_d = '0; hold_t = '0;
            for (int cyc = 0; cyc < 16; cyc++) begin
                out_ready = !(cyc >= 3 && cyc <= 5);
                in_valid  = (sent < 4);
                if (sent < 4) begin
                    in_mode = s_mode[sent]; in_data = s_data[sent];
                    in_shamt = s_sh[sent]; in_tag = 5'(sent + 1);
                end
                #1;
                if (!out_ready) check("stall in_ready", 64'(in_ready), 64'(!out_valid));
                if (hold_v) begin
                    check("stall data stable", 64'(out_data), 64'(hold_d));
                    check("stall tag stable", 64'(out_tag), 64'(hold_t));
                end
                hold_v = out_valid && !out_ready;
                hold_d = out_data;
                hold_t = out_tag;
                if (out_valid && out_ready) begin
                    if (rcvd < 4) begin
                        check("stream tag", 64'(out_tag), 64'(rcvd + 1));
                        check("stream data", 64'(out_data), 64'(s_exp[rcvd]));
                    end
                    rcvd++;
                end
                if (in_valid && in_ready) sent++;
                @(posedge clk); #1;
            end
            in_valid = 1'b0;
            check("stream count", 64'(rcvd), 64'd4);
        end

        // Flush with two ops in flight and a third presented.
        begin
            int n_bad;
            out_ready = 1'b0;
            in_valid = 1'b1; in_mode = 3'd0; in_data = 32'h1; in_shamt = 5'd1; in_tag = 5'd9;
            @(posedge clk); #1;
            in_tag = 5'd10;
            @(posedge clk); #1;
            check("flush pre out_valid", 64'(out_valid), 64'd1);
            in_tag = 5'd11; flush = 1'b1;
            @(posedge clk); #1;
            flush = 1'b0; in_valid = 1'b0;
            check("flush out_valid", 64'(out_valid), 64'd0);
            out_ready = 1'b1;
            n_bad = 0;
            repeat (6) begin
                @(posedge clk); #1;
                if (out_valid) n_bad++;
            end
            check("flush no survivors", 64'(n_bad), 64'd0);
        end

        // Asynchronous reset while a result is parked at the output.
        out_ready = 1'b0;
        in_valid = 1'b1; in_mode = 3'd0; in_data = 32'h1; in_shamt = 5'd4; in_tag = 5'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("pre-reset data", 64'(out_data), 64'h10);
        #2 rst_n = 1'b0;
        #1;
        check("async reset out_valid", 64'(out_valid), 64'd0);
        check("async reset out_data", 64'(out_data), 64'd0);
        check("async reset out_tag", 64'(out_tag), 64'd0);
        check("async reset in_ready", 64'(in_ready), 64'd1);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        run32(3'd1, 32'hF000_000F, 5'd4, 5'd21, 32'h0F00_0000, "after reset");

        // 64-bit, 3-stage sweep against the reference model.
        for (int k = 0; k < 24; k++) begin
            run64(3'($urandom_range(0, 7)), {$urandom, $urandom}, 6'($urandom_range(0, 63)),
                  5'(k));
        end
        run64(3'd2, 64'h8000_0000_0000_0000, 6'd63, 5'd30);
        run64(3'd3, 64'h8000_0000_0000_0001, 6'd1, 5'd31);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d tests run", n_tests);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
